// File: rtl/demo_pkg.sv
// Shared constants for the demo display pipeline: scene count, scene index
// names, sequencer FSM encoding and the visible raster size.
package demo_pkg;

  localparam int NUM_SCENES = 11;

  // Scene indices as seen on background_state
  localparam logic [7:0] SOLID         = 8'd0;
  localparam logic [7:0] H_BARS        = 8'd1;
  localparam logic [7:0] V_BARS        = 8'd2;
  localparam logic [7:0] CHECKER       = 8'd3;
  localparam logic [7:0] GRAD_H        = 8'd4;
  localparam logic [7:0] GRAD_V        = 8'd5;
  localparam logic [7:0] GRID          = 8'd6;
  localparam logic [7:0] DIAG_POS      = 8'd7;
  localparam logic [7:0] DIAG_NEG      = 8'd8;
  localparam logic [7:0] DIAG_BOTH_POS = 8'd9;
  localparam logic [7:0] DIAG_BOTH_NEG = 8'd10;

  // Sequencer FSM encoding
  localparam logic [0:0] ST_AUTO   = 1'b0;
  localparam logic [0:0] ST_PAUSED = 1'b1;

  localparam int V_DISPLAY = 480;
  localparam int H_DISPLAY = 640;

  localparam logic [5:0] SOLID_COLOR_RST = 6'h30;

  // Next scene index, wrapping the last scene back to SOLID. The >= guard
  // also pulls any out-of-range value back into the legal set.
  function automatic logic [7:0] next_scene(input logic [7:0] cur, input int n);
    return (cur >= 8'(n - 1)) ? SOLID : cur + 8'd1;
  endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer followed by a rising-edge detector.
//   clk, rst : clock and synchronous active-high reset
//   btn_raw  : asynchronous button level
//   rise     : one-cycle pulse per synchronized 0->1 transition
module btn_sync (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic rise
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = btn_raw;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/scene_sequencer.sv
// Scene sequencer for the VGA demo. Picks the background scene once per
// frame, either cycling automatically after DWELL_FRAMES frames or stepping
// on a push-button, and slowly walks the solid colour while scene 0 shows.
//   clk, rst         : clock, synchronous active-high reset
//   vpos             : vertical raster position from the timing generator
//   auto_en          : 1 = automatic cycling, 0 = manual stepping
//   step_btn         : raw asynchronous step button
//   background_state : current scene index (registered)
//   solid_color      : {R,G,B} 2b each used by scene 0 (registered)
//   frame_strobe     : one-cycle pulse per frame start
//   scene_changed    : one-cycle pulse when background_state changes
module scene_sequencer
  import demo_pkg::*;
#(
  parameter int DWELL_FRAMES = 120,
  parameter int COLOR_DIV    = 30,
  parameter int NUM_SCENES   = demo_pkg::NUM_SCENES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] vpos,
  input  logic       auto_en,
  input  logic       step_btn,
  output logic [7:0] background_state,
  output logic [5:0] solid_color,
  output logic       frame_strobe,
  output logic       scene_changed
);

  logic [9:0] prev_vpos_q, prev_vpos_d;
  logic [7:0] bg_q, bg_d;
  logic [5:0] solid_q, solid_d;
  logic       strobe_q, strobe_d;
  logic       changed_q, changed_d;
  logic [0:0] state_q, state_d;
  logic [9:0] dwell_q, dwell_d;
  logic [9:0] color_cnt_q, color_cnt_d;
  logic       pend_q, pend_d;

  logic       step_rise;
  logic       frame_start;
  logic       advance;
  logic [7:0] bg_next;

  btn_sync u_btn_sync (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (step_btn),
    .rise    (step_rise)
  );

  // prev_vpos resets to 0, so a reset taken while vpos is 0 cannot fake a
  // frame start; vpos must leave 0 and come back first.
  assign frame_start = (vpos == 10'd0) && (prev_vpos_q != 10'd0);
  assign bg_next     = next_scene(bg_q, NUM_SCENES);

  always_comb begin
    prev_vpos_d = vpos;
    bg_d        = bg_q;
    solid_d     = solid_q;
    strobe_d    = frame_start;
    changed_d   = 1'b0;
    state_d     = state_q;
    dwell_d     = dwell_q;
    color_cnt_d = color_cnt_q;
    advance     = 1'b0;
    // A step edge landing on the consuming frame start survives: the clear
    // only removes the old request, the new rise is OR-ed back in.
    pend_d      = (pend_q & ~frame_start) | step_rise;

    if (frame_start) begin
      // The decision this frame uses the mode latched at the previous frame
      // start; auto_en is sampled now for the next one.
      state_d = auto_en ? ST_AUTO : ST_PAUSED;

      if (state_q == ST_AUTO) begin
        // Expiry and a pending step together still give a single advance.
        if (dwell_q == 10'(DWELL_FRAMES - 1) || pend_q) begin
          advance = 1'b1;
          dwell_d = 10'd0;
        end else begin
          dwell_d = dwell_q + 10'd1;
        end
      end else begin
        advance = pend_q;
      end

      if (bg_q == SOLID) begin
        if (color_cnt_q == 10'(COLOR_DIV - 1)) begin
          solid_d     = solid_q + 6'd1;
          color_cnt_d = 10'd0;
        end else begin
          color_cnt_d = color_cnt_q + 10'd1;
        end
      end

      if (advance) begin
        bg_d      = bg_next;
        changed_d = (bg_next != bg_q);
        // Each visit to scene 0 starts a fresh colour period.
        if (bg_next == SOLID && bg_q != SOLID) color_cnt_d = 10'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_vpos_q <= 10'd0;
      bg_q        <= SOLID;
      solid_q     <= SOLID_COLOR_RST;
      strobe_q    <= 1'b0;
      changed_q   <= 1'b0;
      state_q     <= ST_AUTO;
      dwell_q     <= 10'd0;
      color_cnt_q <= 10'd0;
      pend_q      <= 1'b0;
    end else begin
      prev_vpos_q <= prev_vpos_d;
      bg_q        <= bg_d;
      solid_q     <= solid_d;
      strobe_q    <= strobe_d;
      changed_q   <= changed_d;
      state_q     <= state_d;
      dwell_q     <= dwell_d;
      color_cnt_q <= color_cnt_d;
      pend_q      <= pend_d;
    end
  end

  assign background_state = bg_q;
  assign solid_color      = solid_q;
  assign frame_strobe     = strobe_q;
  assign scene_changed    = changed_q;

endmodule

// File: doc/scene_sequencer.md
SCENE_SEQUENCER -- requirements
Module: scene_sequencer

Interface
REQ-001 SHALL have parameter DWELL_FRAMES, default 120, frames each scene is held in auto mode (legal 1..1023).
REQ-002 SHALL have parameter COLOR_DIV, default 30, frames between solid_color increments in scene 0 (legal 1..1023).
REQ-003 SHALL have parameter NUM_SCENES, default 11, scene count; scenes numbered 0..NUM_SCENES-1.
REQ-004 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port vpos  in  10  current vertical position from the VGA timing generator.
REQ-007 SHALL have port auto_en  in  1  1 = automatic scene cycling, 0 = paused/manual stepping.
REQ-008 SHALL have port step_btn  in  1  raw asynchronous step push-button level.
REQ-009 SHALL have port background_state  out  8  scene select to the pixel colour datapath, registered.
REQ-010 SHALL have port solid_color  out  6  {R,G,B} 2b each for scene 0, registered.
REQ-011 SHALL have port frame_strobe  out  1  one-cycle pulse per frame start, registered.
REQ-012 SHALL have port scene_changed  out  1  one-cycle pulse coincident with any background_state change.

Function
REQ-013 SHALL register vpos into prev_vpos every cycle; frame start = (vpos==0 && prev_vpos!=0).
REQ-014 SHALL assert frame_strobe for exactly one cycle, on the edge where frame start is detected; 1-cycle latency from vpos first reading 0.
REQ-015 SHALL update background_state and solid_color only on frame-start edges (no mid-frame change, no tearing).
REQ-016 SHALL pass step_btn through a 2-FF synchronizer then rising-edge detect; each detected edge sets a step_pending flag.
REQ-017 SHALL implement FSM {AUTO, PAUSED}; state loads from auto_en on each frame-start edge only.
REQ-018 In AUTO, SHALL count frames in dwell_cnt (10b); at frame start with dwell_cnt==DWELL_FRAMES-1 or step_pending, advance scene and clear dwell_cnt, else increment dwell_cnt.
REQ-019 In PAUSED, SHALL hold dwell_cnt; at frame start with step_pending, advance scene one step.
REQ-020 Scene advance SHALL be background_state+1, wrapping NUM_SCENES-1 -> 0; upper bits always zero.
REQ-021 Simultaneous dwell expiry and step_pending SHALL advance exactly one scene and clear both.
REQ-022 step_pending SHALL clear on the frame-start edge that consumes it; multiple edges within one frame collapse to one step.
REQ-023 A step edge arriving on the same cycle as a consuming frame start SHALL remain pending for the next frame.
REQ-024 scene_changed SHALL pulse on the same edge background_state changes, and never otherwise.
REQ-025 While background_state==0, SHALL count frames in color_cnt; at frame start with color_cnt==COLOR_DIV-1, solid_color += 1 (mod 64) and color_cnt clears.
REQ-026 color_cnt SHALL clear on every transition into scene 0; solid_color holds its value in other scenes.

Reset
REQ-027 On rst=1 at a clock edge: background_state=0, solid_color=6'h30, frame_strobe=0, scene_changed=0, FSM=AUTO, dwell_cnt=0, color_cnt=0, step_pending=0, prev_vpos=0, synchronizer flops=0.
REQ-028 Reset mid-frame or mid-dwell SHALL discard all progress; no frame_strobe until the next genuine vpos transition to 0.

Structure
REQ-029 Shared package demo_pkg SHALL hold NUM_SCENES, scene index constants (SOLID=0 .. DIAG_BOTH_NEG=10), FSM state encoding, V_DISPLAY/H_DISPLAY.
REQ-030 SHALL instantiate one sub-module btn_sync (2-FF sync + rising-edge pulse, sync active-high reset); all else inline.

Verification (DWELL_FRAMES=3, COLOR_DIV=2, vpos driven by model frame generator)
REQ-031 Reset then 7 frames, auto_en=1 -> background_state 0,0,0,1,1,1,2; scene_changed pulses exactly twice; frame_strobe pulses 7 times.
REQ-032 Scene 10 with dwell expiry -> background_state wraps to 0, solid_color holds, color_cnt restarts.
REQ-033 Scene 0 held 4 frames -> solid_color 6'h30 -> 6'h31 -> 6'h32; 6'h3F + 1 -> 6'h00.
REQ-034 auto_en=0, three step_btn edges within one frame -> single advance at next frame start; none afterward.
REQ-035 auto_en=1, step edge in frame where dwell_cnt==2 -> exactly one advance, dwell_cnt=0.
REQ-036 rst asserted mid-frame in scene 5 -> next cycle all outputs at reset values; first frame_strobe only after vpos leaves and returns to 0.
